// File: rtl/ffe_seq_controller.sv
// FFE MAC sequencer: walks the tap read address once per sample period,
// strobes the delay-line shift and the accumulator store/clear, drains the
// last accumulation after load drops, and qualifies the stored output.
module ffe_seq_controller #(
    parameter int NUM_TAPS  = 4,
    parameter int ADDR_SIZE = $clog2(NUM_TAPS),
    parameter int CFG_W     = $clog2(NUM_TAPS + 1),
    parameter int STORE_LAT = 1
) (
    input  logic                 ffe_clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [CFG_W-1:0]     taps_cfg,
    output logic                 shift_en,
    output logic                 rd_en,
    output logic                 str_out_n_rst_add_reg,
    output logic [ADDR_SIZE-1:0] rd_addr,
    output logic                 out_valid,
    output logic                 busy
);

    localparam logic [1:0] ST_RESET   = 2'd0;
    localparam logic [1:0] ST_IDLE    = 2'd1;
    localparam logic [1:0] ST_COMPUTE = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    // Active tap count bounds: the store slot must fall inside the period.
    localparam logic [CFG_W-1:0] A_MAX  = CFG_W'(NUM_TAPS);
    localparam logic [CFG_W-1:0] A_MIN  = CFG_W'(STORE_LAT + 1);
    // Drain cycle that carries the final store (STORE_LAT is 0 or 1).
    localparam logic             D_LAST = (STORE_LAT != 0);

    logic [1:0]           state;
    logic [CFG_W-1:0]     a_cnt;
    logic                 drn_cnt;
    logic                 first_per;

    logic                 in_cmp;
    logic                 in_drn;
    logic                 last_cyc;
    logic [ADDR_SIZE-1:0] top_addr;
    logic [ADDR_SIZE-1:0] str_addr;
    logic [CFG_W-1:0]     a_new;

    // Clamp the requested tap count into [STORE_LAT+1, NUM_TAPS]; 0 means "all".
    always_comb begin
        a_new = taps_cfg;
        if (taps_cfg == '0 || taps_cfg > A_MAX)
            a_new = A_MAX;
        else if (taps_cfg < A_MIN)
            a_new = A_MIN;
    end

    // Address decode: period runs 0, A-1, ..., 1 so index k sits at addr A-k.
    always_comb begin
        top_addr = ADDR_SIZE'(a_cnt - CFG_W'(1));
        if (STORE_LAT == 0)
            str_addr = '0;
        else
            str_addr = ADDR_SIZE'(a_cnt - CFG_W'(STORE_LAT));
        // With A=1 every cycle closes a period; otherwise addr 1 is the last.
        last_cyc = (a_cnt == CFG_W'(1)) || (rd_addr == ADDR_SIZE'(1));
    end

    // Strobes are pure decodes of registered state so load never glitches them.
    always_comb begin
        in_cmp                = (state == ST_COMPUTE);
        in_drn                = (state == ST_DRAIN);
        busy                  = in_cmp | in_drn;
        rd_en                 = in_cmp;
        shift_en              = in_cmp && (rd_addr == '0);
        str_out_n_rst_add_reg = (in_cmp && (rd_addr == str_addr)) ||
                                (in_drn && (drn_cnt == D_LAST));
    end

    // Sequencer state, address walk, drain count and output qualification.
    always_ff @(posedge ffe_clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RESET;
            rd_addr   <= '0;
            a_cnt     <= '0;
            drn_cnt   <= 1'b0;
            first_per <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            // The first store of a run only clears the accumulator.
            out_valid <= str_out_n_rst_add_reg && !first_per;
            if (str_out_n_rst_add_reg)
                first_per <= 1'b0;

            case (state)
                ST_RESET: begin
                    state   <= ST_IDLE;
                    rd_addr <= '0;
                    drn_cnt <= 1'b0;
                end
                ST_IDLE: begin
                    rd_addr <= '0;
                    drn_cnt <= 1'b0;
                    if (load) begin
                        state     <= ST_COMPUTE;
                        a_cnt     <= a_new;
                        first_per <= 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    if (last_cyc && !load) begin
                        state   <= ST_DRAIN;
                        rd_addr <= '0;
                        drn_cnt <= 1'b0;
                    end else if (rd_addr == '0) begin
                        rd_addr <= top_addr;
                    end else begin
                        rd_addr <= rd_addr - ADDR_SIZE'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drn_cnt == D_LAST)
                        state <= ST_IDLE;
                    else
                        drn_cnt <= drn_cnt + 1'b1;
                end
                default: begin
                    state   <= ST_RESET;
                    rd_addr <= '0;
                end
            endcase
        end
    end

endmodule
